// File: rtl/traffic_intersection_ctrl.sv
// ============================================================================
// traffic_intersection_ctrl: NS/EW signal controller with pedestrian phase and
// emergency preemption. Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_intersection_ctrl #(
  parameter int GREEN_NS_T = 8,
  parameter int GREEN_EW_T = 6,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1,
  parameter int WALK_T     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       emergency,
  output logic [0:2] light_ns,
  output logic [0:2] light_ew,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
);

  localparam logic [2:0] NS_G  = 3'd0;
  localparam logic [2:0] NS_Y  = 3'd1;
  localparam logic [2:0] AR_A  = 3'd2;
  localparam logic [2:0] WALK  = 3'd3;
  localparam logic [2:0] EW_G  = 3'd4;
  localparam logic [2:0] EW_Y  = 3'd5;
  localparam logic [2:0] AR_B  = 3'd6;
  localparam logic [2:0] EMERG = 3'd7;

  localparam logic [0:2] RED    = 3'b100;
  localparam logic [0:2] GREEN  = 3'b010;
  localparam logic [0:2] YELLOW = 3'b001;

  localparam logic [7:0] LD_NS_G = 8'(GREEN_NS_T - 1);
  localparam logic [7:0] LD_EW_G = 8'(GREEN_EW_T - 1);
  localparam logic [7:0] LD_Y    = 8'(YELLOW_T - 1);
  localparam logic [7:0] LD_AR   = 8'(ALLRED_T - 1);
  localparam logic [7:0] LD_WALK = 8'(WALK_T - 1);

  logic [2:0] state, state_nx;
  logic [7:0] timer, timer_nx, timer_dec;
  logic       expire, ped_nx;
  logic [0:2] ns_nx, ew_nx;
  logic       walk_nx;

  assign state_o   = state;
  assign expire    = tick && (timer == 8'd0);
  assign timer_dec = (tick && (timer != 8'd0)) ? timer - 8'd1 : timer;

  // Lamps are registered from the next state so they switch with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= NS_G;
      timer       <= LD_NS_G;
      light_ns    <= GREEN;
      light_ew    <= RED;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      light_ns    <= ns_nx;
      light_ew    <= ew_nx;
      walk        <= walk_nx;
      ped_pending <= ped_nx;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer_dec;
    case (state)
      NS_G: begin
        if (emergency || (expire && (ew_car || ped_pending))) begin
          state_nx = NS_Y;
          timer_nx = LD_Y;
        end
      end
      NS_Y: begin
        if (expire) begin
          state_nx = emergency ? EMERG : AR_A;
          timer_nx = LD_AR;
        end
      end
      AR_A: begin
        if (emergency) begin
          state_nx = EMERG;
        end else if (expire) begin
          state_nx = ped_pending ? WALK : EW_G;
          timer_nx = ped_pending ? LD_WALK : LD_EW_G;
        end
      end
      WALK: begin
        if (emergency) begin
          state_nx = EMERG;
        end else if (expire) begin
          state_nx = EW_G;
          timer_nx = LD_EW_G;
        end
      end
      EW_G: begin
        if (emergency || expire) begin
          state_nx = EW_Y;
          timer_nx = LD_Y;
        end
      end
      EW_Y: begin
        if (expire) begin
          state_nx = emergency ? EMERG : AR_B;
          timer_nx = LD_AR;
        end
      end
      AR_B: begin
        if (emergency) begin
          state_nx = EMERG;
        end else if (expire) begin
          state_nx = NS_G;
          timer_nx = LD_NS_G;
        end
      end
      EMERG: begin
        timer_nx = timer;
        if (!emergency) begin
          state_nx = AR_B;
          timer_nx = LD_AR;
        end
      end
      default: begin
        state_nx = AR_B;
        timer_nx = LD_AR;
      end
    endcase
  end

  // Entering WALK clears the latch even if the button is pressed on that clk.
  always_comb begin
    ped_nx = ped_pending;
    if (state_nx == WALK && state != WALK) begin
      ped_nx = 1'b0;
    end else if (ped_req && state != WALK) begin
      ped_nx = 1'b1;
    end
    ns_nx   = RED;
    ew_nx   = RED;
    walk_nx = 1'b0;
    case (state_nx)
      NS_G:    ns_nx   = GREEN;
      NS_Y:    ns_nx   = YELLOW;
      WALK:    walk_nx = 1'b1;
      EW_G:    ew_nx   = GREEN;
      EW_Y:    ew_nx   = YELLOW;
      default: ns_nx   = RED;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
// ============================================================================
// tb_traffic_intersection_ctrl: directed scenarios with a scoreboard queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_traffic_intersection_ctrl;

  localparam logic [2:0] NS_G = 3'd0, NS_Y = 3'd1, AR_A = 3'd2, WALK = 3'd3;
  localparam logic [2:0] EW_G = 3'd4, EW_Y = 3'd5, AR_B = 3'd6, EMERG = 3'd7;

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  ns;
    logic [2:0]  ew;
    logic        wk;
    logic        pp;
    logic [7:0]  scn;
    logic [15:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0, tick = 1'b1, ew_car = 1'b0, ped_req = 1'b0, emergency = 1'b0;
  logic [0:2] light_ns, light_ew;
  logic       walk, ped_pending;
  logic [2:0] state_o;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   idx = 0;
  int   scn = 0;
  logic every4 = 1'b0;

  traffic_intersection_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .ew_car(ew_car), .ped_req(ped_req),
    .emergency(emergency), .light_ns(light_ns), .light_ew(light_ew),
    .walk(walk), .ped_pending(ped_pending), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Lamp table for each state: {ns, ew, walk}.
  function automatic logic [6:0] lamps(input logic [2:0] s);
    case (s)
      NS_G:    return {3'b010, 3'b100, 1'b0};
      NS_Y:    return {3'b001, 3'b100, 1'b0};
      WALK:    return {3'b100, 3'b100, 1'b1};
      EW_G:    return {3'b100, 3'b010, 1'b0};
      EW_Y:    return {3'b100, 3'b001, 1'b0};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic step(input logic [2:0] st, input logic pp);
    exp_t e;
    logic [6:0] l;
    tick = every4 ? (((cyc + 1) % 4) == 0) : 1'b1;
    @(posedge clk);
    cyc++;
    l     = lamps(st);
    e.st  = st;
    e.ns  = l[6:4];
    e.ew  = l[3:1];
    e.wk  = l[0];
    e.pp  = pp;
    e.scn = 8'(scn);
    e.idx = 16'(idx);
    q.push_back(e);
    idx++;
    #1;
  endtask

  task automatic run(input logic [2:0] st, input int n, input logic pp);
    for (int i = 0; i < n; i++) step(st, pp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(NS_G, 1'b0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic begin_scn(input int n);
    scn = n;
    idx = 0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (state_o !== e.st || light_ns !== e.ns || light_ew !== e.ew ||
          walk !== e.wk || ped_pending !== e.pp) begin
        errors++;
        $display("FAIL scn%0d cyc%0d: got st=%0d ns=%b ew=%b walk=%b pp=%b, want st=%0d ns=%b ew=%b walk=%b pp=%b",
                 e.scn, e.idx, state_o, light_ns, light_ew, walk, ped_pending,
                 e.st, e.ns, e.ew, e.wk, e.pp);
      end
    end
  end

  initial begin
    // Idle: no demand keeps NS green indefinitely.
    begin_scn(1);
    do_reset();
    run(NS_G, 50, 1'b0);

    // Full vehicle cycle, 22 clk from NS_G back to NS_G.
    begin_scn(2);
    ew_car = 1'b1;
    do_reset();
    run(NS_G, 7, 1'b0);
    run(NS_Y, 3, 1'b0);
    run(AR_A, 1, 1'b0);
    run(EW_G, 6, 1'b0);
    run(EW_Y, 3, 1'b0);
    run(AR_B, 1, 1'b0);
    run(NS_G, 8, 1'b0);
    run(NS_Y, 1, 1'b0);

    // Pedestrian pulse at clk 2 leads through WALK.
    begin_scn(3);
    ew_car = 1'b0;
    do_reset();
    run(NS_G, 1, 1'b0);
    ped_req = 1'b1;
    run(NS_G, 1, 1'b1);
    ped_req = 1'b0;
    run(NS_G, 5, 1'b1);
    run(NS_Y, 3, 1'b1);
    run(AR_A, 1, 1'b1);
    run(WALK, 5, 1'b0);
    run(EW_G, 6, 1'b0);
    run(EW_Y, 3, 1'b0);
    run(AR_B, 1, 1'b0);
    run(NS_G, 5, 1'b0);

    // Emergency at 4th EW_G clk; pending pedestrian survives EMERG.
    begin_scn(4);
    ew_car = 1'b1;
    do_reset();
    run(NS_G, 7, 1'b0);
    run(NS_Y, 3, 1'b0);
    run(AR_A, 1, 1'b0);
    ped_req = 1'b1;
    run(EW_G, 1, 1'b1);
    ped_req = 1'b0;
    run(EW_G, 3, 1'b1);
    emergency = 1'b1;
    run(EW_Y, 3, 1'b1);
    run(EMERG, 7, 1'b1);
    emergency = 1'b0;
    run(AR_B, 1, 1'b1);
    run(NS_G, 1, 1'b1);

    // Tick every 4th clk stretches each phase by four.
    begin_scn(5);
    ew_car = 1'b1;
    every4 = 1'b1;
    do_reset();
    run(NS_G, 31, 1'b0);
    run(NS_Y, 12, 1'b0);
    run(AR_A, 4, 1'b0);
    run(EW_G, 2, 1'b0);
    every4 = 1'b0;

    // Button ignored in WALK; reset beats emergency and pending request.
    begin_scn(6);
    ew_car = 1'b0;
    do_reset();
    run(NS_G, 1, 1'b0);
    ped_req = 1'b1;
    run(NS_G, 1, 1'b1);
    ped_req = 1'b0;
    run(NS_G, 5, 1'b1);
    run(NS_Y, 3, 1'b1);
    run(AR_A, 1, 1'b1);
    run(WALK, 2, 1'b0);
    ped_req = 1'b1;
    run(WALK, 1, 1'b0);
    emergency = 1'b1;
    do_reset();
    ped_req = 1'b0;
    emergency = 1'b0;
    run(NS_G, 3, 1'b0);

    // Emergency during NS green forces yellow then EMERG.
    begin_scn(7);
    ew_car = 1'b0;
    do_reset();
    run(NS_G, 2, 1'b0);
    emergency = 1'b1;
    run(NS_Y, 3, 1'b0);
    run(EMERG, 2, 1'b0);
    emergency = 1'b0;
    run(AR_B, 1, 1'b0);
    run(NS_G, 2, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
